alarm_bank_set: RTL and testbench

Multi-slot successor to the single alarm setter. Holds NUM_ALARMS alarm times with per-slot enables. While the FSM is in the alarm-set state, the user edits one slot at a time via the 5-way buttons: digit increment/decrement with proper wrap, slot select, and enable toggle. Independently of state, it compares every enabled slot against the RTC and pulses a match to the alarm/buzzer logic.

---
 rtl/alarm_bank_set_if.sv | 25 ++
 rtl/alarm_bank_set.sv | 133 +++++++++++++
 tb/tb_alarm_bank_set.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_bank_set_if.sv
// Bus bundle for alarm_bank_set: user/RTC inputs and edit/match outputs.
interface alarm_bank_set_if #(
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned IDX_W      = 2
);
  logic [3:0]            STATE;
  logic [4:0]            BUTTONS;
  logic [17:0]           RTC_DATA;
  logic [IDX_W-1:0]      SEL_IDX;
  logic [2:0]            CURSOR;
  logic [17:0]           EDIT_DATA;
  logic [NUM_ALARMS-1:0] ALARM_EN;
  logic                  ALARM_MATCH;
  logic [IDX_W-1:0]      MATCH_IDX;

  modport master (
    output STATE, BUTTONS, RTC_DATA,
    input  SEL_IDX, CURSOR, EDIT_DATA, ALARM_EN, ALARM_MATCH, MATCH_IDX
  );

  modport slave (
    input  STATE, BUTTONS, RTC_DATA,
    output SEL_IDX, CURSOR, EDIT_DATA, ALARM_EN, ALARM_MATCH, MATCH_IDX
  );
endinterface

// File: rtl/alarm_bank_set.sv
// Multi-slot alarm editor: button-driven editing of a working copy while in the
// set state, plus per-slot enables and RTC match pulse generation in every state.
module alarm_bank_set #(
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned IDX_W      = 2,
  parameter logic [3:0]  SET_STATE  = 4'b0111
) (
  input logic             CLK,
  input logic             RESET,
  alarm_bank_set_if.slave bus
);
  localparam logic [4:0] BTN_UP     = 5'b10000;
  localparam logic [4:0] BTN_DOWN   = 5'b01000;
  localparam logic [4:0] BTN_CENTER = 5'b00100;
  localparam logic [4:0] BTN_LEFT   = 5'b00010;
  localparam logic [4:0] BTN_RIGHT  = 5'b00001;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ALARMS - 1);

  logic [4:0]            btn_prev_q, press;
  logic                  in_set, in_set_q, entry;
  logic [16:0]           slot_q [NUM_ALARMS];
  logic [16:0]           work_q, work_d;
  logic [IDX_W-1:0]      sel_q, sel_d;
  logic [2:0]            cursor_q, cursor_d;
  logic [NUM_ALARMS-1:0] en_q, en_d;
  logic                  commit;
  logic [17:0]           rtc_prev_q;
  logic                  rtc_changed, hit;
  logic [IDX_W-1:0]      hit_idx;
  logic                  match_q;
  logic [IDX_W-1:0]      match_idx_q;

  function automatic logic [5:0] ones_step(input logic [5:0] v, input logic up);
    if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  function automatic logic [5:0] tens_step(input logic [5:0] v, input logic up);
    if (up) return (v < 6'd50) ? v + 6'd10 : v - 6'd50;
    return (v >= 6'd10) ? v - 6'd10 : v + 6'd50;
  endfunction

  function automatic logic [4:0] hour_step(input logic [4:0] v, input logic up);
    if (up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  assign in_set = (bus.STATE == SET_STATE);
  assign entry  = in_set & ~in_set_q;
  assign press  = bus.BUTTONS & ~btn_prev_q;

  // Multi-bit presses fall into the default arm and are ignored.
  always_comb begin
    work_d   = work_q;
    sel_d    = sel_q;
    cursor_d = cursor_q;
    en_d     = en_q;
    commit   = 1'b0;
    if (entry) begin
      work_d = slot_q[sel_q];
    end else if (in_set) begin
      case (press)
        BTN_UP, BTN_DOWN: begin
          case (cursor_q)
            3'd0: work_d[5:0]   = ones_step(work_q[5:0], press[4]);
            3'd1: work_d[5:0]   = tens_step(work_q[5:0], press[4]);
            3'd2: work_d[11:6]  = ones_step(work_q[11:6], press[4]);
            3'd3: work_d[11:6]  = tens_step(work_q[11:6], press[4]);
            3'd4: work_d[16:12] = hour_step(work_q[16:12], press[4]);
            3'd5: begin
              if (press[4]) sel_d = (sel_q == LAST_IDX) ? '0 : sel_q + IDX_W'(1);
              else          sel_d = (sel_q == '0) ? LAST_IDX : sel_q - IDX_W'(1);
              work_d = slot_q[sel_d];
            end
            3'd6:    en_d[sel_q] = ~en_q[sel_q];
            default: ;
          endcase
        end
        BTN_CENTER: commit   = 1'b1;
        BTN_LEFT:   cursor_d = (cursor_q == 3'd6) ? 3'd0 : cursor_q + 3'd1;
        BTN_RIGHT:  cursor_d = (cursor_q == 3'd0) ? 3'd6 : cursor_q - 3'd1;
        default:    ;
      endcase
    end
  end

  // Descending scan so the lowest matching slot wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (en_q[i] && (slot_q[i] == bus.RTC_DATA[16:0])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign rtc_changed = (bus.RTC_DATA != rtc_prev_q);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      btn_prev_q  <= '0;
      in_set_q    <= 1'b0;
      work_q      <= '0;
      sel_q       <= '0;
      cursor_q    <= '0;
      en_q        <= '0;
      rtc_prev_q  <= '0;
      match_q     <= 1'b0;
      match_idx_q <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) slot_q[i] <= '0;
    end else begin
      btn_prev_q <= bus.BUTTONS;
      in_set_q   <= in_set;
      work_q     <= work_d;
      sel_q      <= sel_d;
      cursor_q   <= cursor_d;
      en_q       <= en_d;
      rtc_prev_q <= bus.RTC_DATA;
      match_q    <= hit & rtc_changed;
      if (hit && rtc_changed) match_idx_q <= hit_idx;
      if (commit) slot_q[sel_q] <= work_q;
    end
  end

  assign bus.SEL_IDX     = sel_q;
  assign bus.CURSOR      = cursor_q;
  assign bus.EDIT_DATA   = {1'b0, work_q};
  assign bus.ALARM_EN    = en_q;
  assign bus.ALARM_MATCH = match_q;
  assign bus.MATCH_IDX   = match_idx_q;
endmodule

// File: tb/tb_alarm_bank_set.sv
// Bench for alarm_bank_set: directed edit/match scenarios, then random stimulus
// against a behavioural model using modular time arithmetic.
module tb_alarm_bank_set;
  localparam int unsigned NUM_ALARMS = 4;
  localparam int unsigned IDX_W      = 2;
  localparam logic [3:0]  SET_STATE  = 4'b0111;
  localparam int          NA         = NUM_ALARMS;
  localparam logic [4:0]  B_UP = 5'b10000, B_DN = 5'b01000, B_C = 5'b00100;
  localparam logic [4:0]  B_L  = 5'b00010, B_R  = 5'b00001;

  logic CLK = 1'b0;
  logic RESET;

  alarm_bank_set_if #(.NUM_ALARMS(NUM_ALARMS), .IDX_W(IDX_W)) bus ();

  alarm_bank_set #(
    .NUM_ALARMS(NUM_ALARMS),
    .IDX_W     (IDX_W),
    .SET_STATE (SET_STATE)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int              m_hr[NA], m_mn[NA], m_sc[NA];
  int              w_hr, w_mn, w_sc, m_sel, m_cur, e_midx;
  logic [NA-1:0]   m_en;
  logic [4:0]      m_btn_prev;
  logic            m_was_set, e_match;
  logic [17:0]     m_rtc_prev;
  logic [17:0]     rtc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp,
               $time);
    end
  endtask

  function automatic logic [16:0] pack(input int h, input int m, input int s);
    return {h[4:0], m[5:0], s[5:0]};
  endfunction

  function automatic logic [16:0] slot_val(input int i);
    return pack(m_hr[i], m_mn[i], m_sc[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      m_hr[i] = 0; m_mn[i] = 0; m_sc[i] = 0;
    end
    w_hr = 0; w_mn = 0; w_sc = 0; m_sel = 0; m_cur = 0; e_midx = 0;
    m_en = '0; m_btn_prev = '0; m_was_set = 1'b0; e_match = 1'b0; m_rtc_prev = '0;
  endtask

  task automatic load_work(input int i);
    w_hr = m_hr[i]; w_mn = m_mn[i]; w_sc = m_sc[i];
  endtask

  task automatic model_edge(input logic [3:0] st, input logic [4:0] btn, input logic [17:0] r);
    logic [4:0] p;
    int         d;
    bit         found;
    p       = btn & ~m_btn_prev;
    found   = 0;
    e_match = 1'b0;
    if (r != m_rtc_prev) begin
      for (int i = 0; i < NA; i++) begin
        if (!found && m_en[i] && slot_val(i) == r[16:0]) begin
          found = 1; e_match = 1'b1; e_midx = i;
        end
      end
    end
    if (st == SET_STATE && !m_was_set) begin
      load_work(m_sel);
    end else if (st == SET_STATE) begin
      if (p == B_UP || p == B_DN) begin
        d = (p == B_UP) ? 1 : -1;
        case (m_cur)
          0: w_sc = (w_sc + 60 + d) % 60;
          1: w_sc = (w_sc + 60 + 10 * d) % 60;
          2: w_mn = (w_mn + 60 + d) % 60;
          3: w_mn = (w_mn + 60 + 10 * d) % 60;
          4: w_hr = (w_hr + 24 + d) % 24;
          5: begin
            m_sel = (m_sel + NA + d) % NA;
            load_work(m_sel);
          end
          6: m_en[m_sel] = ~m_en[m_sel];
          default: ;
        endcase
      end else if (p == B_C) begin
        m_hr[m_sel] = w_hr; m_mn[m_sel] = w_mn; m_sc[m_sel] = w_sc;
      end else if (p == B_L) begin
        m_cur = (m_cur + 1) % 7;
      end else if (p == B_R) begin
        m_cur = (m_cur + 6) % 7;
      end
    end
    m_btn_prev = btn;
    m_was_set  = (st == SET_STATE);
    m_rtc_prev = r;
  endtask

  task automatic check_all();
    check("sel_idx", 32'(bus.SEL_IDX), 32'(m_sel));
    check("cursor", 32'(bus.CURSOR), 32'(m_cur));
    check("edit_data", 32'(bus.EDIT_DATA), 32'({1'b0, pack(w_hr, w_mn, w_sc)}));
    check("alarm_en", 32'(bus.ALARM_EN), 32'(m_en));
    check("alarm_match", 32'(bus.ALARM_MATCH), 32'(e_match));
    check("match_idx", 32'(bus.MATCH_IDX), 32'(e_midx));
  endtask

  task automatic step(input logic [3:0] st, input logic [4:0] btn);
    bus.STATE    = st;
    bus.BUTTONS  = btn;
    bus.RTC_DATA = rtc;
    @(posedge CLK);
    model_edge(st, btn, rtc);
    #1;
    check_all();
  endtask

  task automatic press(input logic [4:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      step(SET_STATE, b);
      step(SET_STATE, 5'd0);
    end
  endtask

  // Asynchronous clear is sampled well before the next clock edge.
  task automatic do_reset();
    RESET = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge CLK);
    #1;
    check_all();
    RESET = 1'b0;
  endtask

  task automatic rtc_hit(input string tag, input logic exp_m, input int exp_i);
    rtc = {1'b0, pack(7, 29, 59)};
    step(SET_STATE, 5'd0);
    rtc = {1'b0, pack(7, 30, 0)};
    step(SET_STATE, 5'd0);
    check({tag, "_match"}, 32'(bus.ALARM_MATCH), 32'(exp_m));
    check({tag, "_idx"}, 32'(bus.MATCH_IDX), 32'(exp_i));
  endtask

  task automatic run_random(input int cycles);
    logic [3:0] st;
    logic [4:0] b;
    int         r;
    for (int k = 0; k < cycles; k++) begin
      r  = int'($urandom_range(0, 99));
      st = (r < 85) ? SET_STATE : 4'($urandom_range(0, 15));
      r  = int'($urandom_range(0, 9));
      if (r < 4)      b = 5'd0;
      else if (r < 9) b = 5'(1 << $urandom_range(0, 4));
      else            b = 5'($urandom);
      r = int'($urandom_range(0, 9));
      if (r < 2)      rtc = {1'b0, slot_val(int'($urandom_range(0, NA - 1)))};
      else if (r < 4) rtc = {1'b0, pack(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                                        int'($urandom_range(0, 59)))};
      else if (r < 5) rtc = 18'($urandom);
      step(st, b);
      if ($urandom_range(0, 399) == 0) do_reset();
    end
  endtask

  initial begin
    int pulses;
    RESET        = 1'b0;
    rtc          = '0;
    bus.STATE    = 4'd0;
    bus.BUTTONS  = 5'd0;
    bus.RTC_DATA = '0;
    #1;
    do_reset();

    // Digit wrap behaviour
    step(4'd0, 5'd0);
    step(4'd0, 5'd0);
    step(SET_STATE, 5'd0);
    press(B_DN, 1);
    check("sec_wrap_down", 32'(bus.EDIT_DATA[5:0]), 32'd59);
    press(B_UP, 1);
    check("sec_wrap_up", 32'(bus.EDIT_DATA[5:0]), 32'd0);
    press(B_L, 4);
    check("cursor_hour", 32'(bus.CURSOR), 32'd4);
    press(B_DN, 1);
    check("hour_wrap_down", 32'(bus.EDIT_DATA[16:12]), 32'd23);
    press(B_R, 4);
    press(B_DN, 15);
    press(B_L, 1);
    press(B_UP, 1);
    check("sec_tens_up", 32'(bus.EDIT_DATA[5:0]), 32'd55);
    press(B_UP, 1);
    check("sec_tens_wrap_up", 32'(bus.EDIT_DATA[5:0]), 32'd5);
    press(B_DN, 1);
    check("sec_tens_wrap_dn", 32'(bus.EDIT_DATA[5:0]), 32'd55);
    press(B_L, 1);
    press(B_UP, 7);
    press(B_L, 1);
    press(B_DN, 1);
    check("min_tens_wrap_dn", 32'(bus.EDIT_DATA[11:6]), 32'd57);

    // Slot programming and slot select
    do_reset();
    step(SET_STATE, 5'd0);
    press(B_L, 4);
    press(B_UP, 7);
    press(B_R, 1);
    press(B_UP, 3);
    press(B_C, 1);
    press(B_L, 2);
    press(B_UP, 1);
    check("sel_up", 32'(bus.SEL_IDX), 32'd1);
    check("sel_up_data", 32'(bus.EDIT_DATA), 32'd0);
    press(B_DN, 1);
    check("sel_down", 32'(bus.SEL_IDX), 32'd0);
    check("sel_down_data", 32'(bus.EDIT_DATA), 32'({1'b0, pack(7, 30, 0)}));
    press(B_UP, 2);
    press(B_R, 1);
    press(B_UP, 7);
    press(B_R, 1);
    press(B_UP, 3);
    press(B_C, 1);
    press(B_L, 3);
    press(B_UP, 1);
    press(B_R, 1);
    press(B_DN, 2);
    press(B_L, 1);
    press(B_UP, 1);
    check("en_both", 32'(bus.ALARM_EN), 32'h5);

    // Matching, priority and no re-trigger
    rtc_hit("hit_slot0", 1'b1, 0);
    pulses = 0;
    for (int k = 0; k < 100; k++) begin
      step(SET_STATE, 5'd0);
      if (bus.ALARM_MATCH) pulses++;
    end
    check("no_retrigger", 32'(pulses), 32'd0);
    press(B_UP, 1);
    rtc_hit("hit_slot2", 1'b1, 2);
    press(B_R, 1);
    press(B_UP, 2);
    press(B_L, 1);
    press(B_UP, 1);
    check("en_none", 32'(bus.ALARM_EN), 32'h0);
    rtc_hit("no_hit", 1'b0, 2);

    // Discard on exit, multi-press ignored, reset mid-edit
    press(B_L, 5);
    press(B_UP, 2);
    check("hour_edit", 32'(bus.EDIT_DATA[16:12]), 32'd9);
    step(4'd0, 5'd0);
    step(SET_STATE, 5'd0);
    check("discard_on_exit", 32'(bus.EDIT_DATA), 32'({1'b0, pack(7, 30, 0)}));
    for (int k = 0; k < 3; k++) step(SET_STATE, B_UP | B_DN);
    check("multi_press_ignored", 32'(bus.EDIT_DATA), 32'({1'b0, pack(7, 30, 0)}));
    step(SET_STATE, 5'd0);
    press(B_UP, 1);
    do_reset();
    check("reset_edit", 32'(bus.EDIT_DATA), 32'd0);
    check("reset_en", 32'(bus.ALARM_EN), 32'd0);

    run_random(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
